// File: rtl/rs232_word_rx_if.sv
// rs232_word_rx_if: serial line input and word/status outputs of the RS-232 word receiver
`timescale 1ns/1ps
interface rs232_word_rx_if #(parameter int NBYTES = 2);
    logic                  r_di;
    logic [8*NBYTES-1:0]   r_q;
    logic                  r_dv_o;
    logic                  r_err_o;
    logic [1:0]            r_err_code_o;
    logic                  r_busy_o;
    modport master (output r_di, input r_q, r_dv_o, r_err_o, r_err_code_o, r_busy_o);
    modport slave  (input r_di, output r_q, r_dv_o, r_err_o, r_err_code_o, r_busy_o);
endinterface

// File: rtl/rs232_word_rx.sv
// rs232_word_rx: UART receiver assembling NBYTES bytes into one word, with parity, framing and inter-byte timeout checks
`timescale 1ns/1ps
module rs232_word_rx #(
    parameter int NBYTES       = 2,
    parameter int CLK_DIV      = 100,
    parameter int PARITY       = 0,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          clk_ref,
    input  logic          rst_n,
    rs232_word_rx_if.slave rx
);
    localparam int W     = 8 * NBYTES;
    localparam int TW    = $clog2(CLK_DIV);
    localparam int LIMIT = TIMEOUT_BITS * CLK_DIV;
    localparam int OW    = $clog2(LIMIT + 1);
    localparam logic [1:0] LAST  = 2'(NBYTES - 1);
    localparam logic [1:0] E_FRM = 2'b01;
    localparam logic [1:0] E_PAR = 2'b10;
    localparam logic [1:0] E_TMO = 2'b11;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_t;

    state_t         state_q, state_d;
    logic           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [1:0]     vld_q, vld_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [OW-1:0]  tmo_q, tmo_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           perr_q, perr_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [W-1:0]   word_q, word_d, q_q, q_d;
    logic           dv_q, dv_d, err_q, err_d, busy_q, busy_d;
    logic [1:0]     code_q, code_d;
    logic           fall, tick_half, tick_bit, abort;
    logic [1:0]     abort_code;

    // vld holds off edge detection until the synchroniser carries real line samples, so a line low at reset release is not a start edge
    assign fall      = prev_q & ~sync2_q;
    assign tick_half = tmr_q == TW'(CLK_DIV / 2 - 1);
    assign tick_bit  = tmr_q == TW'(CLK_DIV - 1);

    assign rx.r_q          = q_q;
    assign rx.r_dv_o       = dv_q;
    assign rx.r_err_o      = err_q;
    assign rx.r_err_code_o = code_q;
    assign rx.r_busy_o     = busy_q;

    // next-state logic: synchroniser, bit timing, byte/word assembly and error handling
    always_comb begin
        sync1_d    = rx.r_di;
        sync2_d    = sync1_q;
        vld_d      = {vld_q[0], 1'b1};
        prev_d     = vld_q[1] & sync2_q;
        state_d    = state_q;
        tmr_d      = tmr_q + 1'b1;
        tmo_d      = (tmo_q == OW'(LIMIT)) ? tmo_q : tmo_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        q_d        = q_q;
        dv_d       = 1'b0;
        err_d      = 1'b0;
        code_d     = code_q;
        abort      = 1'b0;
        abort_code = code_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (fall) state_d = START;
            end
            START: if (tick_half) begin
                tmr_d = '0;
                if (sync2_q) state_d = (byte_cnt_q == 2'd0) ? IDLE : GAP;
                else begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    perr_d    = 1'b0;
                end
            end
            DATA: if (tick_bit) begin
                tmr_d     = '0;
                shreg_d   = {sync2_q, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 3'd7) state_d = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (tick_bit) begin
                tmr_d   = '0;
                perr_d  = (^shreg_q ^ sync2_q) != (PARITY == 2);
                state_d = STOP;
            end
            STOP: if (tick_bit) begin
                tmr_d = '0;
                tmo_d = '0;
                if (!sync2_q) begin
                    abort      = 1'b1;
                    abort_code = E_FRM;
                end else if (perr_q) begin
                    abort      = 1'b1;
                    abort_code = E_PAR;
                end else begin
                    word_d[byte_cnt_q*8 +: 8] = shreg_q;
                    if (byte_cnt_q == LAST) begin
                        q_d        = word_d;
                        dv_d       = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = GAP;
                    end
                end
            end
            GAP: begin
                tmr_d = '0;
                if (fall) state_d = START;
                else if (tmo_q >= OW'(LIMIT - 1)) begin
                    abort      = 1'b1;
                    abort_code = E_TMO;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            err_d      = 1'b1;
            code_d     = abort_code;
            byte_cnt_d = '0;
            state_d    = IDLE;
        end
        busy_d = state_d != IDLE;
    end

    // state and output registers, cleared asynchronously by rst_n
    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b0;
            vld_q      <= '0;
            tmr_q      <= '0;
            tmo_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            q_q        <= '0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            vld_q      <= vld_d;
            tmr_q      <= tmr_d;
            tmo_q      <= tmo_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            q_q        <= q_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            code_q     <= code_d;
            busy_q     <= busy_d;
        end
    end
endmodule

// File: tb/tb_rs232_word_rx.sv
// tb_rs232_word_rx: scoreboard bench for rs232_word_rx (2-byte no-parity and 1-byte even-parity instances)
`timescale 1ns/1ps
module tb_rs232_word_rx;
    localparam int BIT = 2000;

    typedef struct {
        bit          is_err;
        logic [31:0] q;
        logic [1:0]  code;
    } ev_t;

    logic clk_ref = 1'b0;
    logic rst_n   = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    always #10 clk_ref = ~clk_ref;

    rs232_word_rx_if #(.NBYTES(2)) if0 ();
    rs232_word_rx_if #(.NBYTES(1)) if1 ();

    rs232_word_rx dut0 (.clk_ref(clk_ref), .rst_n(rst_n), .rx(if0.slave));
    rs232_word_rx #(.NBYTES(1), .PARITY(1)) dut1 (.clk_ref(clk_ref), .rst_n(rst_n), .rx(if1.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) if0.r_di = v;
        else if1.r_di = v;
    endtask

    // par < 0 sends no parity bit
    task automatic send_byte(input int w, input logic [7:0] b, input int par, input logic stop);
        set_line(w, 1'b0);
        #BIT;
        for (int i = 0; i < 8; i++) begin
            set_line(w, b[i]);
            #BIT;
        end
        if (par >= 0) begin
            set_line(w, par[0]);
            #BIT;
        end
        set_line(w, stop);
        #BIT;
        set_line(w, 1'b1);
    endtask

    task automatic push(input int w, input bit is_err, input logic [31:0] q, input logic [1:0] code);
        ev_t e;
        e.is_err = is_err;
        e.q      = q;
        e.code   = code;
        if (w == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic drain(input int w);
        for (int i = 0; i < 5000 && (w == 0 ? q0.size() : q1.size()) != 0; i++) @(posedge clk_ref);
        check_eq($sformatf("drain%0d", w), w == 0 ? q0.size() : q1.size(), 0);
    endtask

    task automatic observe(input int w, input logic dv, input logic err, input logic [31:0] q,
                           input logic [1:0] code, input logic busy);
        ev_t e;
        check_eq($sformatf("dut%0d_dv_err_excl", w), dv & err, 0);
        check_eq($sformatf("dut%0d_busy_drop", w), busy, 0);
        if ((w == 0 ? q0.size() : q1.size()) == 0)
            check_eq($sformatf("dut%0d_unexpected_dv_err", w), {dv, err}, 0);
        else begin
            e = (w == 0) ? q0.pop_front() : q1.pop_front();
            check_eq($sformatf("dut%0d_kind_err", w), err, e.is_err);
            check_eq($sformatf("dut%0d_r_q", w), q, e.q);
            if (e.is_err) check_eq($sformatf("dut%0d_code", w), code, e.code);
        end
    endtask

    always @(negedge clk_ref)
        if (rst_n && (if0.r_dv_o || if0.r_err_o))
            observe(0, if0.r_dv_o, if0.r_err_o, 32'(if0.r_q), if0.r_err_code_o, if0.r_busy_o);

    always @(negedge clk_ref)
        if (rst_n && (if1.r_dv_o || if1.r_err_o))
            observe(1, if1.r_dv_o, if1.r_err_o, 32'(if1.r_q), if1.r_err_code_o, if1.r_busy_o);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.r_di = 1'b1;
        if1.r_di = 1'b1;
        #55;
        check_eq("rst_r_q", if0.r_q, 0);
        check_eq("rst_dv", if0.r_dv_o, 0);
        check_eq("rst_err", if0.r_err_o, 0);
        check_eq("rst_code", if0.r_err_code_o, 0);
        check_eq("rst_busy", if0.r_busy_o, 0);
        check_eq("rst_busy1", if1.r_busy_o, 0);
        #50 rst_n = 1'b1;
        #1000;
        // two good bytes -> one word, first byte in the low lane
        push(0, 0, 32'h3700, 2'b00);
        send_byte(0, 8'h00, -1, 1'b1);
        #5000;
        send_byte(0, 8'h37, -1, 1'b1);
        drain(0);
        // second byte with a low stop bit -> framing abort, r_q kept
        push(0, 1, 32'h3700, 2'b01);
        send_byte(0, 8'h55, -1, 1'b1);
        #3000;
        send_byte(0, 8'h66, -1, 1'b0);
        #(3 * BIT);
        drain(0);
        // lone byte then idle past the timeout, then a good word
        push(0, 1, 32'h3700, 2'b11);
        send_byte(0, 8'h11, -1, 1'b1);
        #(21 * BIT);
        drain(0);
        push(0, 0, 32'hBBAA, 2'b00);
        send_byte(0, 8'hAA, -1, 1'b1);
        #3000;
        send_byte(0, 8'hBB, -1, 1'b1);
        drain(0);
        check_eq("code_held", if0.r_err_code_o, 2'b11);
        // short low glitch: busy briefly, then back to idle with nothing reported
        set_line(0, 1'b0);
        #200;
        set_line(0, 1'b1);
        #200;
        check_eq("glitch_busy", if0.r_busy_o, 1);
        #BIT;
        check_eq("glitch_idle", if0.r_busy_o, 0);
        check_eq("glitch_r_q", if0.r_q, 32'hBBAA);
        // reset in the middle of the second byte discards the partial word
        send_byte(0, 8'h12, -1, 1'b1);
        #3000;
        set_line(0, 1'b0);
        #(4 * BIT);
        rst_n = 1'b0;
        #50;
        check_eq("midrst_r_q", if0.r_q, 0);
        check_eq("midrst_busy", if0.r_busy_o, 0);
        #50 rst_n = 1'b1;
        #(5 * BIT - 100);
        set_line(0, 1'b1);
        #(3 * BIT);
        push(0, 0, 32'h4441, 2'b00);
        send_byte(0, 8'h41, -1, 1'b1);
        #3000;
        send_byte(0, 8'h44, -1, 1'b1);
        drain(0);
        // even parity, single-byte words
        push(1, 1, 32'h00, 2'b10);
        send_byte(1, 8'h41, 1, 1'b1);
        #(2 * BIT);
        drain(1);
        push(1, 0, 32'h41, 2'b00);
        send_byte(1, 8'h41, 0, 1'b1);
        drain(1);
        push(1, 0, 32'h07, 2'b00);
        send_byte(1, 8'h07, 1, 1'b1);
        drain(1);
        // bad parity and bad stop together: framing wins
        push(1, 1, 32'h07, 2'b01);
        send_byte(1, 8'h7E, 1, 1'b0);
        #(2 * BIT);
        drain(1);
        check_eq("dut0_quiet_r_q", if0.r_q, 32'h4441);
        #BIT;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
